// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and build-time legality check for fifo_sync_thresh.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_sync_pkg;

    // Default configuration, used as interface and top defaults.
    localparam int DEF_DSIZE  = 8;
    localparam int DEF_ASIZE  = 4;
    localparam int DEF_AFULL  = 12;
    localparam int DEF_AEMPTY = 2;

    // Pointer width for the default configuration. One extra bit above the
    // address tells full apart from empty when the addresses match.
    localparam int PTR_W = DEF_ASIZE + 1;

    function automatic int depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    // Thresholds must leave a non-empty band between almost-empty and
    // almost-full, and almost-full must be reachable before the FIFO is full.
    function automatic bit thresh_ok(input int asize, input int afull, input int aempty);
        return (aempty >= 0) && (aempty < afull) && (afull <= depth(asize) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_thresh_if.sv
// Producer/consumer bundle for fifo_sync_thresh: write side, read side, status.
// Latency: n/a (wires only).
// Backpressure: producer watches wfull/walmost_full, consumer watches rempty/rvalid.
// Ports: master = user of the FIFO (drives wdata/winc/rinc), slave = the FIFO.
interface fifo_sync_thresh_if
    import fifo_sync_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
);
    // write side
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             wovf;
    // read side
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             ralmost_empty;
    logic             rudf;
    // occupancy, 0..2**ASIZE
    logic [ASIZE:0]   count;

    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, wovf,
        input  rdata, rvalid, rempty, ralmost_empty, rudf, count
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, wovf,
        output rdata, rvalid, rempty, ralmost_empty, rudf, count
    );
endinterface

// File: rtl/fifo_sync_mem.sv
// DEPTH x DSIZE storage: synchronous write port, read port registered (default) or asynchronous (FIFO_SYNC_FWFT_EN).
// Latency: write lands 1 edge after we_i; registered read 1 edge after re_i, async read 0 cycles.
// Backpressure: none; caller only asserts we_i/re_i for accepted transfers.
// Ports: clk, rst (clears read register only), we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);
    localparam int DEPTH = depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is always on the output; pops are tracked by the pointers.
    logic unused_rd_ctl;
    assign unused_rd_ctl = ^{rst, re_i};
    assign rdata_o       = mem_q[raddr_i];
`else
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] rdata_d;

    // Hold the last word read until the next accepted read.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and overflow/underflow pulses.
// Latency: write visible to reader after 1 edge; standard read data 1 edge after rinc, FWFT head shown with 0 cycles.
// Backpressure: wfull rejects writes (wovf pulses), rempty rejects reads (rudf pulses); walmost_full gives early warning.
// Ports: clk, rst (sync, active-high), bus (fifo_sync_thresh_if.slave).
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through read mode.
module fifo_sync_thresh
    import fifo_sync_pkg::*;
#(
    parameter int DSIZE         = DEF_DSIZE,
    parameter int ASIZE         = DEF_ASIZE,
    parameter int AFULL_THRESH  = DEF_AFULL,
    parameter int AEMPTY_THRESH = DEF_AEMPTY
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_sync_thresh_if.slave    bus
);
    localparam int PW = ptr_width(ASIZE);

    if (!thresh_ok(ASIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
        $fatal(1, "fifo_sync_thresh: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH-1");
    end

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          wovf_q, wovf_d;
    logic          rudf_q, rudf_d;
    logic [PW-1:0] count_w;
    logic          full_w;
    logic          empty_w;
    logic          wr_acc;
    logic          rd_acc;

    // Status is decoded from the registered pointers only, so it never
    // depends on this cycle's requests.
    assign count_w = wptr_q - rptr_q;
    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                     (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

    // Acceptance uses the pre-edge flags: at full a read still drains while
    // the write bounces; at empty a write lands while the read bounces.
    assign wr_acc = bus.winc && !full_w;
    assign rd_acc = bus.rinc && !empty_w;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        wovf_d = bus.winc && full_w;
        rudf_d = bus.rinc && empty_w;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            wovf_q <= 1'b0;
            rudf_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            wovf_q <= wovf_d;
            rudf_q <= rudf_d;
        end
    end

    fifo_sync_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (bus.wdata),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (bus.rdata)
    );

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is valid whenever something is stored.
    assign bus.rvalid = !empty_w;
`else
    logic rvalid_q, rvalid_d;

    always_comb begin
        rvalid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rvalid = rvalid_q;
`endif

    assign bus.count         = count_w;
    assign bus.rempty        = empty_w;
    assign bus.wfull         = full_w;
    assign bus.walmost_full  = (count_w >= PW'(AFULL_THRESH));
    assign bus.ralmost_empty = (count_w <= PW'(AEMPTY_THRESH));
    assign bus.wovf          = wovf_q;
    assign bus.rudf          = rudf_q;

endmodule
